// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates an instruction-fetch port and a load/store port onto a
// byte-wide memory, moving one byte per cycle (little-endian).
//
// Ports:
//   clock, reset        - system clock, synchronous active-high reset
//   if_req/if_addr      - fetch request (always a 4-byte read)
//   if_data/if_done     - fetched word and one-cycle completion pulse
//   ls_req/ls_rw        - load/store request, 1 = store
//   ls_width            - 00 byte, 01 half, 10/11 word
//   ls_addr/ls_wdata    - load/store address and store data
//   ls_rdata/ls_done    - zero-extended load data and one-cycle completion pulse
//   mem_rw/mem_addr     - byte-memory write enable and address
//   mem_write/mem_read  - byte-memory write data and combinational read data
//
// Configuration:
//   MEM_CTRL_RR_EN defined   - round-robin arbitration on contention
//   MEM_CTRL_RR_EN undefined - fixed priority, load/store wins
module mem_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_data,
    output logic        if_done,
    input  logic        ls_req,
    input  logic        ls_rw,
    input  logic [1:0]  ls_width,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic [31:0] ls_rdata,
    output logic        ls_done,
    output logic        mem_rw,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_write,
    input  logic [7:0]  mem_read
);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t      state_q, state_d;
    logic        gnt_ls_q, gnt_ls_d;     // requester owning the current transfer
    logic        last_ls_q, last_ls_d;   // most recent grant, 0 = IF
    logic [31:0] addr_q, addr_d;
    logic        rw_q, rw_d;
    logic [1:0]  kmax_q, kmax_d;         // index of the last byte (N-1)
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  k_q, k_d;
    logic [31:0] acc_q, acc_d;           // read bytes gathered so far
    logic [31:0] if_data_q, if_data_d;
    logic [31:0] ls_rdata_q, ls_rdata_d;
    logic        if_done_q, if_done_d;
    logic        ls_done_q, ls_done_d;
    logic        mem_rw_q, mem_rw_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_write_q, mem_write_d;

    logic        grant_ls;
    logic [31:0] sel_addr;
    logic        sel_rw;
    logic [31:0] sel_wdata;
    logic [1:0]  sel_kmax;
    logic [1:0]  k_nxt;
    logic [31:0] acc_ins;

`ifdef MEM_CTRL_RR_EN
    // On contention the side not granted most recently wins.
    assign grant_ls = ls_req && (!if_req || !last_ls_q);
`else
    assign grant_ls = ls_req;
`endif

    assign k_nxt = k_q + 2'd1;

    // Request fields of whichever side wins arbitration this cycle.
    always_comb begin
        sel_addr  = if_addr;
        sel_rw    = 1'b0;
        sel_wdata = 32'h0;
        sel_kmax  = 2'd3;
        if (grant_ls) begin
            sel_addr  = ls_addr;
            sel_rw    = ls_rw;
            sel_wdata = ls_wdata;
            case (ls_width)
                2'b00:   sel_kmax = 2'd0;
                2'b01:   sel_kmax = 2'd1;
                default: sel_kmax = 2'd3;
            endcase
        end
    end

    always_comb begin
        acc_ins                    = acc_q;
        acc_ins[{k_q, 3'b000} +: 8] = mem_read;

        state_d     = state_q;
        gnt_ls_d    = gnt_ls_q;
        last_ls_d   = last_ls_q;
        addr_d      = addr_q;
        rw_d        = rw_q;
        kmax_d      = kmax_q;
        wdata_d     = wdata_q;
        k_d         = k_q;
        acc_d       = acc_q;
        if_data_d   = if_data_q;
        ls_rdata_d  = ls_rdata_q;
        // Pulses and memory drive are zero unless set below, which keeps them
        // low in IDLE and DONE.
        if_done_d   = 1'b0;
        ls_done_d   = 1'b0;
        mem_rw_d    = 1'b0;
        mem_addr_d  = 32'h0;
        mem_write_d = 8'h0;

        case (state_q)
            IDLE: begin
                if (if_req || ls_req) begin
                    state_d     = BUSY;
                    gnt_ls_d    = grant_ls;
                    last_ls_d   = grant_ls;
                    addr_d      = sel_addr;
                    rw_d        = sel_rw;
                    wdata_d     = sel_wdata;
                    kmax_d      = sel_kmax;
                    k_d         = 2'd0;
                    acc_d       = 32'h0;
                    // Outputs are registered, so byte 0 is set up here.
                    mem_addr_d  = sel_addr;
                    mem_rw_d    = sel_rw;
                    mem_write_d = sel_rw ? sel_wdata[7:0] : 8'h0;
                end
            end
            BUSY: begin
                acc_d = acc_ins;
                if (k_q == kmax_q) begin
                    state_d = DONE;
                    if (gnt_ls_q) begin
                        ls_done_d  = 1'b1;
                        ls_rdata_d = rw_q ? 32'h0 : acc_ins;
                    end else begin
                        if_done_d = 1'b1;
                        if_data_d = acc_ins;
                    end
                end else begin
                    k_d         = k_nxt;
                    mem_addr_d  = addr_q + {30'd0, k_nxt};
                    mem_rw_d    = rw_q;
                    mem_write_d = rw_q ? wdata_q[{k_nxt, 3'b000} +: 8] : 8'h0;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            gnt_ls_q    <= 1'b0;
            last_ls_q   <= 1'b0;
            addr_q      <= 32'h0;
            rw_q        <= 1'b0;
            kmax_q      <= 2'd0;
            wdata_q     <= 32'h0;
            k_q         <= 2'd0;
            acc_q       <= 32'h0;
            if_data_q   <= 32'h0;
            ls_rdata_q  <= 32'h0;
            if_done_q   <= 1'b0;
            ls_done_q   <= 1'b0;
            mem_rw_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_write_q <= 8'h0;
        end else begin
            state_q     <= state_d;
            gnt_ls_q    <= gnt_ls_d;
            last_ls_q   <= last_ls_d;
            addr_q      <= addr_d;
            rw_q        <= rw_d;
            kmax_q      <= kmax_d;
            wdata_q     <= wdata_d;
            k_q         <= k_d;
            acc_q       <= acc_d;
            if_data_q   <= if_data_d;
            ls_rdata_q  <= ls_rdata_d;
            if_done_q   <= if_done_d;
            ls_done_q   <= ls_done_d;
            mem_rw_q    <= mem_rw_d;
            mem_addr_q  <= mem_addr_d;
            mem_write_q <= mem_write_d;
        end
    end

    // Gating with reset keeps the memory side quiet while reset is held, so a
    // transfer interrupted by reset issues no write in the reset cycle.
    assign mem_rw    = mem_rw_q & ~reset;
    assign mem_addr  = reset ? 32'h0 : mem_addr_q;
    assign mem_write = reset ? 8'h0 : mem_write_q;
    assign if_done   = if_done_q & ~reset;
    assign ls_done   = ls_done_q & ~reset;
    assign if_data   = if_data_q;
    assign ls_rdata  = ls_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic [31:0] if_data;
    logic        if_done;
    logic        ls_req = 1'b0;
    logic        ls_rw = 1'b0;
    logic [1:0]  ls_width = 2'b00;
    logic [31:0] ls_addr = 32'h0;
    logic [31:0] ls_wdata = 32'h0;
    logic [31:0] ls_rdata;
    logic        ls_done;
    logic        mem_rw;
    logic [31:0] mem_addr;
    logic [7:0]  mem_write;
    logic [7:0]  mem_read;

    int errors = 0;
    int checks = 0;

    logic [7:0]  bmem [0:1023];   // memory attached to the DUT
    logic [7:0]  mm   [0:1023];   // reference copy kept by the bench
    bit          last_ls_m;
    logic [31:0] addr_log [$];
    int          ls_done_cnt = 0;
    int          wr_total = 0;

    always #5 clock = ~clock;

    mem_ctrl dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
        .ls_req(ls_req), .ls_rw(ls_rw), .ls_width(ls_width), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_rdata(ls_rdata), .ls_done(ls_done),
        .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_write(mem_write), .mem_read(mem_read)
    );

    assign mem_read = bmem[mem_addr[9:0]];
    always @(posedge clock) if (mem_rw) bmem[mem_addr[9:0]] <= mem_write;

    always @(negedge clock) begin
        if (ls_done) ls_done_cnt++;
        if (mem_rw) wr_total++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int len_of(bit is_ls, logic [1:0] w);
        if (!is_ls) return 4;
        case (w)
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] model_load(logic [31:0] a, int n);
        logic [31:0] r;
        logic [31:0] ai;
        r = 32'h0;
        for (int i = 0; i < n; i++) begin
            ai = a + i;
            r[8*i +: 8] = mm[ai[9:0]];
        end
        return r;
    endfunction

    // Single-requester transfer, started and finished on a falling edge.
    task automatic xfer(input bit is_ls, input bit rw, input logic [1:0] w,
                        input logic [31:0] a, input logic [31:0] wd, input bit drop,
                        input string tag, output logic [31:0] rd);
        int n, lat, wr_cnt;
        bit got;
        logic [31:0] exp, ai;
        n = len_of(is_ls, w);
        if (is_ls) begin
            ls_rw = rw; ls_width = w; ls_addr = a; ls_wdata = wd; ls_req = 1'b1;
        end else begin
            if_addr = a; if_req = 1'b1;
        end
        lat = 0; wr_cnt = 0; got = 1'b0;
        addr_log.delete();
        while (!got && lat < 20) begin
            @(posedge clock); @(negedge clock); lat++;
            if (drop) begin
                ls_req = 1'b0; ls_addr = ~a; ls_wdata = ~wd; ls_rw = ~rw; ls_width = ~w;
            end
            got = is_ls ? ls_done : if_done;
            if (!got) begin
                addr_log.push_back(mem_addr);
                if (mem_rw) wr_cnt++;
            end
        end
        rd = is_ls ? ls_rdata : if_data;
        if_req = 1'b0; ls_req = 1'b0;
        chk({tag, " done"}, 32'(got), 32'd1);
        chk({tag, " latency"}, lat, n + 1);
        chk({tag, " other_done"}, 32'(is_ls ? if_done : ls_done), 32'd0);
        chk({tag, " mem_rw_cycles"}, wr_cnt, (is_ls && rw) ? n : 0);
        for (int i = 0; i < addr_log.size(); i++)
            chk({tag, " mem_addr"}, addr_log[i], a + i);
        if (is_ls && rw) begin
            exp = 32'h0;
            for (int i = 0; i < n; i++) begin
                ai = a + i;
                mm[ai[9:0]] = wd[8*i +: 8];
            end
        end else begin
            exp = model_load(a, n);
        end
        chk({tag, " rdata"}, rd, exp);
        last_ls_m = is_ls;
        @(negedge clock);
        chk({tag, " pulse_width"}, 32'(is_ls ? ls_done : if_done), 32'd0);
        if (is_ls && rw) begin
            for (int i = 0; i < n; i++) begin
                ai = a + i;
                chk({tag, " mem_byte"}, bmem[ai[9:0]], mm[ai[9:0]]);
            end
        end
    endtask

    typedef struct {
        bit          is_ls;
        bit          rw;
        logic [1:0]  w;
        logic [31:0] a;
        logic [31:0] wd;
        bit          drop;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vt [10];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] ra;
        bit          exp_order [3];
        int          cnt, done_snap, wr_snap;
        bit          is_ls, rw, drop;
        logic [1:0]  w;

        for (int i = 0; i < 1024; i++) begin
            mm[i]   = 8'((i * 37 + 11) & 255);
            bmem[i] <= 8'((i * 37 + 11) & 255);
        end
        mm[100] = 8'h66; mm[101] = 8'hDB; mm[102] = 8'hFF; mm[103] = 8'h55;
        mm[1022] = 8'h12; mm[1023] = 8'h34; mm[0] = 8'h56; mm[1] = 8'h78;
        bmem[100] <= 8'h66; bmem[101] <= 8'hDB; bmem[102] <= 8'hFF; bmem[103] <= 8'h55;
        bmem[1022] <= 8'h12; bmem[1023] <= 8'h34; bmem[0] <= 8'h56; bmem[1] <= 8'h78;
        last_ls_m = 1'b0;

        vt[0] = '{1'b0, 1'b0, 2'b10, 32'd100,        32'h0,        1'b0, 32'h55FFDB66};
        vt[1] = '{1'b1, 1'b1, 2'b10, 32'd200,        32'hA1B2C3D4, 1'b0, 32'h00000000};
        vt[2] = '{1'b1, 1'b0, 2'b01, 32'd202,        32'h0,        1'b0, 32'h0000A1B2};
        vt[3] = '{1'b1, 1'b0, 2'b00, 32'd103,        32'h0,        1'b1, 32'h00000055};
        vt[4] = '{1'b1, 1'b0, 2'b10, 32'hFFFFFFFE,   32'h0,        1'b0, 32'h78563412};
        vt[5] = '{1'b1, 1'b0, 2'b01, 32'd101,        32'h0,        1'b0, 32'h0000FFDB};
        vt[6] = '{1'b1, 1'b1, 2'b11, 32'd400,        32'h11223344, 1'b0, 32'h00000000};
        vt[7] = '{1'b1, 1'b0, 2'b11, 32'd400,        32'h0,        1'b0, 32'h11223344};
        vt[8] = '{1'b1, 1'b1, 2'b00, 32'd201,        32'hFFFFFF99, 1'b0, 32'h00000000};
        vt[9] = '{1'b1, 1'b0, 2'b10, 32'd200,        32'h0,        1'b0, 32'hA1B299D4};

        // Reset: a store request held during reset must not reach memory.
        ls_req = 1'b1; ls_rw = 1'b1; ls_width = 2'b10; ls_addr = 32'd500; ls_wdata = 32'hDEADBEEF;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset if_done", 32'(if_done), 32'd0);
        chk("reset ls_done", 32'(ls_done), 32'd0);
        chk("reset mem_rw", 32'(mem_rw), 32'd0);
        chk("reset mem_addr", mem_addr, 32'h0);
        chk("reset mem_write", 32'(mem_write), 32'd0);
        ls_req = 1'b0;
        reset = 1'b0;
        chk("reset if_data", if_data, 32'h0);
        chk("reset ls_rdata", ls_rdata, 32'h0);

        for (int i = 0; i < 10; i++) begin
            xfer(vt[i].is_ls, vt[i].rw, vt[i].w, vt[i].a, vt[i].wd, vt[i].drop, $sformatf("vec%0d", i), rd);
            chk($sformatf("vec%0d table_rdata", i), rd, vt[i].exp_rd);
        end

        // Reset during byte 2 of a word store to 300.
        ls_rw = 1'b1; ls_width = 2'b10; ls_addr = 32'd300; ls_wdata = 32'hCAFEBABE; ls_req = 1'b1;
        @(posedge clock); @(negedge clock);
        chk("rst_mid k0 mem_addr", mem_addr, 32'd300);
        @(posedge clock); @(negedge clock);
        @(posedge clock); @(negedge clock);
        chk("rst_mid k2 mem_addr", mem_addr, 32'd302);
        reset = 1'b1; ls_req = 1'b0;
        #1;
        chk("rst_mid gated mem_rw", 32'(mem_rw), 32'd0);
        chk("rst_mid gated mem_addr", mem_addr, 32'h0);
        @(posedge clock); @(negedge clock);
        reset = 1'b0;
        done_snap = ls_done_cnt; wr_snap = wr_total;
        mm[300] = 8'hBE; mm[301] = 8'hBA;
        last_ls_m = 1'b0;
        xfer(1'b0, 1'b0, 2'b10, 32'd100, 32'h0, 1'b0, "post_reset_if", rd);
        chk("rst_mid no ls_done", ls_done_cnt, done_snap);
        chk("rst_mid no writes", wr_total, wr_snap);
        for (int i = 300; i < 304; i++)
            chk($sformatf("rst_mid byte%0d", i), bmem[i], mm[i]);

        // Contention with both requests held.
`ifdef MEM_CTRL_RR_EN
        exp_order = '{1'b1, 1'b0, 1'b1};
`else
        exp_order = '{1'b1, 1'b1, 1'b1};
`endif
        if_addr = 32'd0; ls_rw = 1'b0; ls_width = 2'b10; ls_addr = 32'd100;
        if_req = 1'b1; ls_req = 1'b1;
        for (int g = 0; g < 4; g++) begin
            if (g == 3) ls_req = 1'b0;
            cnt = 0;
            while (!(if_done || ls_done) && cnt < 20) begin
                @(posedge clock); @(negedge clock); cnt++;
            end
            chk($sformatf("arb%0d in_time", g), 32'(cnt < 20), 32'd1);
            chk($sformatf("arb%0d both_done", g), 32'(if_done && ls_done), 32'd0);
            chk($sformatf("arb%0d winner_ls", g), 32'(ls_done), (g == 3) ? 32'd0 : 32'(exp_order[g]));
            if (ls_done) chk($sformatf("arb%0d ls_rdata", g), ls_rdata, model_load(32'd100, 4));
            else         chk($sformatf("arb%0d if_data", g), if_data, model_load(32'd0, 4));
            last_ls_m = ls_done;
            if (g == 3) if_req = 1'b0;
            @(posedge clock); @(negedge clock);
        end

        // Randomized single-requester traffic against the reference model.
        for (int t = 0; t < 40; t++) begin
            is_ls = 1'($urandom_range(0, 3) != 0);
            rw    = is_ls ? 1'($urandom_range(0, 1)) : 1'b0;
            w     = 2'($urandom_range(0, 3));
            ra    = ($urandom_range(0, 4) == 0) ? (32'hFFFFFFFC + 32'($urandom_range(0, 3))) : $urandom;
            drop  = is_ls && ($urandom_range(0, 3) == 0);
            xfer(is_ls, rw, w, ra, $urandom, drop, $sformatf("rand%0d", t), rd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
